// File: rtl/global_avg_unpool_2d_if.sv
// -----------------------------------------------------------------------------
// global_avg_unpool_2d_if
// Stream bundle for global_avg_unpool_2d: the pooled-scalar input channel
// (In / Valid_IN / Ready_OUT) and the broadcast pixel output channel
// (Out / Valid_OUT / Ready_IN / Last_OUT).
//   slave  : the unpool block (consumes In, produces Out)
//   master : the environment (upstream source plus downstream sink)
// -----------------------------------------------------------------------------
interface global_avg_unpool_2d_if #(
    parameter int Datawidth = 16
);
    logic [Datawidth-1:0] In;
    logic                 Valid_IN;
    logic                 Ready_OUT;
    logic [Datawidth-1:0] Out;
    logic                 Valid_OUT;
    logic                 Ready_IN;
    logic                 Last_OUT;

    modport slave (
        input  In, Valid_IN, Ready_IN,
        output Ready_OUT, Out, Valid_OUT, Last_OUT
    );

    modport master (
        output In, Valid_IN, Ready_IN,
        input  Ready_OUT, Out, Valid_OUT, Last_OUT
    );
endinterface

// File: rtl/global_avg_unpool_2d.sv
// -----------------------------------------------------------------------------
// global_avg_unpool_2d
// Streaming inverse of a global average pool. Each pooled scalar taken from
// the input channel is broadcast as a full IMG_Width x IMG_Height raster,
// optionally divided by the window area (Scale) and clamped at zero (ReLU).
// A small FIFO decouples the input from the frame emitter.
// Ports:
//   CLK : rising-edge clock
//   CLR : asynchronous active-low reset; discards the frame in flight and
//         every queued sample
//   bus : global_avg_unpool_2d_if.slave
//         In/Valid_IN/Ready_OUT            - pooled sample input
//         Out/Valid_OUT/Ready_IN/Last_OUT  - broadcast pixel output
// -----------------------------------------------------------------------------
module global_avg_unpool_2d #(
    parameter int IMG_Width  = 7,
    parameter int IMG_Height = 7,
    parameter int Datawidth  = 16,
    parameter int FIFO_Depth = 4,
    parameter bit Scale      = 1'b1,
    parameter bit ReLU       = 1'b0
) (
    input  logic                   CLK,
    input  logic                   CLR,
    global_avg_unpool_2d_if.slave  bus
);
    localparam int AREA = IMG_Width * IMG_Height;
    localparam int PW   = (FIFO_Depth > 1) ? $clog2(FIFO_Depth) : 1;
    localparam int CW   = (IMG_Width  > 1) ? $clog2(IMG_Width)  : 1;
    localparam int HW   = (IMG_Height > 1) ? $clog2(IMG_Height) : 1;

    localparam logic signed [31:0] AREA_S     = 32'(AREA);
    localparam logic [CW-1:0]      COT_LAST   = CW'(IMG_Width - 1);
    localparam logic [HW-1:0]      HANG_LAST  = HW'(IMG_Height - 1);
    localparam logic [PW:0]        FIFO_FULL  = (PW+1)'(FIFO_Depth);
    localparam logic               ONE_PIXEL  = (AREA == 1);

    typedef enum logic {IDLE, EMIT} state_t;

    // ---------------- input FIFO ----------------
    logic [Datawidth-1:0] r_mem [FIFO_Depth];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [PW:0]          r_count;

    // ---------------- emitter ----------------
    state_t               r_state;
    logic [Datawidth-1:0] r_hold;
    logic                 r_valid;
    logic                 r_last;
    logic [CW-1:0]        r_cot;
    logic [HW-1:0]        r_hang;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_not_empty;
    logic                 w_xfer;
    logic                 w_beat_last;
    logic signed [31:0]   w_head_ext;
    logic signed [31:0]   w_quot;
    logic [Datawidth-1:0] w_scaled;
    logic [CW-1:0]        w_cot_nxt;
    logic [HW-1:0]        w_hang_nxt;

    // Ready depends on the registered count only, so a full FIFO never
    // accepts even when a pop happens in the same cycle.
    assign bus.Ready_OUT = (r_count != FIFO_FULL);
    assign bus.Out       = r_hold;
    assign bus.Valid_OUT = r_valid;
    assign bus.Last_OUT  = r_last;

    assign w_push      = bus.Valid_IN && bus.Ready_OUT;
    assign w_not_empty = (r_count != '0);
    assign w_xfer      = r_valid && bus.Ready_IN;
    assign w_beat_last = (r_cot == COT_LAST) && (r_hang == HANG_LAST);
    // Pop when starting from idle, or on the last beat so the next frame
    // follows without a bubble.
    assign w_pop       = w_not_empty &&
                         ((r_state == IDLE) || (w_xfer && w_beat_last));

    // Scaling of the FIFO head: signed division truncates toward zero,
    // ReLU is applied to the quotient, then the result is cut to Datawidth.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_head_ext = 32'(signed'(r_mem[r_rd_ptr]));
        w_quot     = Scale ? (w_head_ext / AREA_S) : w_head_ext;
        w_scaled   = w_quot[Datawidth-1:0];
        if (ReLU && (w_quot < 0)) begin
            w_scaled = '0;
        end
    end

    // Raster position of the beat that follows the current one.
    always_comb begin
        w_cot_nxt  = r_cot + 1'b1;
        w_hang_nxt = r_hang;
        if (r_cot == COT_LAST) begin
            w_cot_nxt  = '0;
            w_hang_nxt = r_hang + 1'b1;
        end
    end

    // NOTE: FIFO storage is deliberately left out of reset; only pointers and
    // count define validity, so clearing the array would be wasted logic.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.In;
        end
    end

    // NOTE: sequential state is always updated with non-blocking assignments.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_cot   <= '0;
            r_hang  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_not_empty) begin
                        r_hold  <= w_scaled;
                        r_valid <= 1'b1;
                        r_last  <= ONE_PIXEL;
                        r_cot   <= '0;
                        r_hang  <= '0;
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    if (w_xfer) begin
                        if (w_beat_last) begin
                            r_cot  <= '0;
                            r_hang <= '0;
                            if (w_not_empty) begin
                                r_hold <= w_scaled;
                                r_last <= ONE_PIXEL;
                            end else begin
                                r_valid <= 1'b0;
                                r_last  <= 1'b0;
                                r_state <= IDLE;
                            end
                        end else begin
                            r_cot  <= w_cot_nxt;
                            r_hang <= w_hang_nxt;
                            r_last <= (w_cot_nxt == COT_LAST) &&
                                      (w_hang_nxt == HANG_LAST);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_global_avg_unpool_2d.sv
// -----------------------------------------------------------------------------
// tb_global_avg_unpool_2d
// Two instances share one stimulus stream: dut0 with ReLU=0, dut1 with ReLU=1
// (both Scale=1, 7x7). Accepted inputs are expanded into expected frames by a
// reference model and queued; a negedge monitor pops and compares each beat.
// -----------------------------------------------------------------------------
module tb_global_avg_unpool_2d;
    localparam int W    = 7;
    localparam int H    = 7;
    localparam int DW   = 16;
    localparam int AREA = W * H;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          CLK = 1'b0;
    logic          CLR = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          rdy = 1'b0;
    logic          rdy_manual = 1'b1;
    int            mode = 0;   // 0 manual, 1 pattern 1,0,0,1, 2 random
    int            pat = 0;

    int checks = 0;
    int errors = 0;
    int beat_cnt0 = 0;
    int acc_beats = 0;

    beat_t         sb [2][$];
    logic          prev_stall [2];
    logic [DW-1:0] prev_out [2];
    logic          prev_last [2];

    logic          vo [2];
    logic          lo [2];
    logic          ro [2];
    logic [DW-1:0] oo [2];

    global_avg_unpool_2d_if #(.Datawidth(DW)) bus0 ();
    global_avg_unpool_2d_if #(.Datawidth(DW)) bus1 ();

    assign bus0.In = in_data;  assign bus0.Valid_IN = in_valid;  assign bus0.Ready_IN = rdy;
    assign bus1.In = in_data;  assign bus1.Valid_IN = in_valid;  assign bus1.Ready_IN = rdy;
    assign vo[0] = bus0.Valid_OUT;  assign vo[1] = bus1.Valid_OUT;
    assign lo[0] = bus0.Last_OUT;   assign lo[1] = bus1.Last_OUT;
    assign ro[0] = bus0.Ready_OUT;  assign ro[1] = bus1.Ready_OUT;
    assign oo[0] = bus0.Out;        assign oo[1] = bus1.Out;

    global_avg_unpool_2d #(.IMG_Width(W), .IMG_Height(H), .Datawidth(DW),
                           .FIFO_Depth(4), .Scale(1'b1), .ReLU(1'b0))
        dut0 (.CLK(CLK), .CLR(CLR), .bus(bus0.slave));

    global_avg_unpool_2d #(.IMG_Width(W), .IMG_Height(H), .Datawidth(DW),
                           .FIFO_Depth(4), .Scale(1'b1), .ReLU(1'b1))
        dut1 (.CLK(CLK), .CLR(CLR), .bus(bus1.slave));

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Average-pool gradient: value / area, rounded toward zero, optional clamp.
    function automatic logic [DW-1:0] ref_val(input int v, input bit relu);
        int q;
        q = v / AREA;
        if (relu && q < 0) q = 0;
        return DW'(q);
    endfunction

    // Ready_IN driver
    always begin
        @(posedge CLK);
        #1;
        pat++;
        case (mode)
            0:       rdy = rdy_manual;
            1:       rdy = ((pat % 4) == 0) || ((pat % 4) == 3);
            default: rdy = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor / scoreboard
    always @(negedge CLK) begin
        int beats_before;
        beat_t exp;
        if (!CLR) begin
            prev_stall[0] = 1'b0;
            prev_stall[1] = 1'b0;
        end else begin
            beats_before = beat_cnt0;
            for (int i = 0; i < 2; i++) begin
                if (prev_stall[i]) begin
                    check("stall_valid", 32'(vo[i]), 32'd1);
                    check("stall_out",   32'(oo[i]), 32'(prev_out[i]));
                    check("stall_last",  32'(lo[i]), 32'(prev_last[i]));
                end
                if (vo[i] && rdy) begin
                    if (sb[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat dut%0d actual=%0h expected=none", i, oo[i]);
                    end else begin
                        exp = sb[i].pop_front();
                        check("beat_data", 32'(oo[i]), 32'(exp.data));
                        check("beat_last", 32'(lo[i]), 32'(exp.last));
                    end
                    if (i == 0) beat_cnt0++;
                end
                prev_stall[i] = vo[i] && !rdy;
                prev_out[i]   = oo[i];
                prev_last[i]  = lo[i];
            end
            if (in_valid && ro[0]) begin
                acc_beats = beats_before;
                for (int i = 0; i < 2; i++)
                    for (int k = 0; k < AREA; k++)
                        sb[i].push_back('{ref_val(int'($signed(in_data)), i == 1), k == AREA - 1});
            end
        end
    end

    task automatic align();
        @(posedge CLK);
        #1;
    endtask

    // Starts at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic push(input logic [DW-1:0] v);
        bit ok;
        ok = 1'b0;
        in_data  = v;
        in_valid = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge CLK);
            if (ro[0]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        check("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge CLK);
            #1;
            if (sb[0].size() == 0 && sb[1].size() == 0 && !vo[0] && !vo[1]) begin
                done = 1'b1;
                break;
            end
        end
        check("drain", 32'(done), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        // ---------------- reset values ----------------
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_out",   32'(oo[i]), 32'd0);
            check("rst_valid", 32'(vo[i]), 32'd0);
            check("rst_last",  32'(lo[i]), 32'd0);
            check("rst_ready", 32'(ro[i]), 32'd1);
        end
        #2 CLR = 1'b1;

        // ---------------- 98 -> 49 beats of 2, latency ----------------
        repeat (2) align();
        push(16'd98);
        @(negedge CLK);
        check("latency_lo", 32'(vo[0]), 32'd0);
        @(negedge CLK);
        check("latency_hi", 32'(vo[0]), 32'd1);
        wait_drain(200);
        repeat (3) @(negedge CLK);
        check("idle_after", 32'(vo[0]), 32'd0);

        // ---------------- -100 with and without ReLU ----------------
        align();
        push(16'hFF9C);
        wait_drain(200);

        // ---------------- back-to-back 147, 49 ----------------
        align();
        push(16'd147);
        push(16'd49);
        for (int k = 0; k < 2 * AREA; k++) begin
            @(negedge CLK);
            check("no_bubble", 32'(vo[0]), 32'd1);
        end
        @(negedge CLK);
        check("b2b_end", 32'(vo[0]), 32'd0);
        wait_drain(50);

        // ---------------- Ready_IN 1,0,0,1 toggling ----------------
        align();
        base = beat_cnt0;
        mode = 1;
        push(16'(-1234));
        wait_drain(500);
        mode = 0;
        check("toggle_beats", 32'(beat_cnt0 - base), 32'(AREA));

        // ---------------- backpressure: 6 pushes with Ready_IN=0 ----------------
        rdy_manual = 1'b0;
        repeat (2) align();
        base = beat_cnt0;
        for (int k = 0; k < 5; k++) push(DW'($urandom));
        check("ready_full", 32'(ro[0]), 32'd0);
        fork
            push(DW'($urandom));
            begin
                repeat (10) @(posedge CLK);
                #1 rdy_manual = 1'b1;
            end
        join
        check("sixth_accept_beats", 32'(acc_beats - base), 32'(AREA));
        wait_drain(1000);

        // ---------------- async reset mid-frame ----------------
        align();
        base = beat_cnt0;
        push(16'd500);
        push(16'd600);
        push(16'd700);
        for (int k = 0; k < 200 && beat_cnt0 < base + 20; k++) begin
            @(negedge CLK);
            #1;
        end
        check("reached_beat20", 32'(beat_cnt0 - base), 32'd20);
        #2 CLR = 1'b0;
        sb[0].delete();
        sb[1].delete();
        #1;
        check("arst_valid0", 32'(vo[0]), 32'd0);
        check("arst_valid1", 32'(vo[1]), 32'd0);
        check("arst_last",   32'(lo[0]), 32'd0);
        #13 CLR = 1'b1;
        @(negedge CLK);
        check("arst_ready", 32'(ro[0]), 32'd1);
        base = beat_cnt0;
        repeat (150) @(negedge CLK);
        check("no_beats_after_rst", 32'(beat_cnt0 - base), 32'd0);

        // ---------------- random ----------------
        align();
        mode = 2;
        for (int k = 0; k < 8; k++) push(DW'($urandom));
        wait_drain(3000);
        mode = 0;

        repeat (3) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/global_avg_unpool_2d.md
Name: global_avg_unpool_2d

Overview:
- Streaming inverse of the global 7x7 average-pool stage, used on the reconstruction and backward path.
- Accepts one pooled scalar per channel from a valid/ready source.
- For each scalar it emits a full IMG_Width x IMG_Height raster stream of that value, optionally divided by the window area (the average-pool gradient).
- Includes a small input FIFO and full valid/ready backpressure toward the downstream line-buffer or convolution stage.

Parameters:
- IMG_Width, 7, columns per emitted frame.
- IMG_Height, 7, rows per emitted frame.
- Datawidth, 16, signed two's-complement sample width.
- FIFO_Depth, 4, input FIFO entries (power of 2, >=2).
- Scale, 1, 1: Out = In / (IMG_Width*IMG_Height); 0: Out = In.
- ReLU, 0, 1: negative scaled values clamp to 0.

Ports:
- CLK  input  1  clock, rising edge.
- CLR  input  1  reset, asynchronous, active-low.
- In  input  Datawidth  pooled sample.
- Valid_IN  input  1  In is valid.
- Ready_OUT  output  1  block can accept In; Ready_OUT = (fifo_count != FIFO_Depth).
- Out  output  Datawidth  broadcast pixel.
- Valid_OUT  output  1  Out is valid.
- Ready_IN  input  1  downstream accepts Out.
- Last_OUT  output  1  Out is the final pixel (row H-1, col W-1) of its frame.

Behaviour:
- Reset (CLR=0, async):
  - Out=0, Valid_OUT=0, Last_OUT=0.
  - fifo_count=0 and FIFO pointers=0.
  - cot=0, hang=0, state=IDLE, hold register=0.
  - Ready_OUT goes high as soon as the count clears.
  - Reset mid-frame discards the frame in progress and all FIFO contents; no partial frame resumes after release.
- Input push: when Valid_IN && Ready_OUT at a rising edge, In is written at the write pointer and fifo_count increments.
  - Ready_OUT depends only on the registered count, not on a same-cycle pop, so the FIFO never overflows.
  - Input is ignored when Valid_IN=1 and Ready_OUT=0.
- Scaling, computed combinationally on the FIFO head:
  - Signed division by the constant IMG_Width*IMG_Height, truncating toward zero. Examples: -100/49 = -2; 48/49 = 0.
  - ReLU, when enabled, is applied after division.
  - The result is truncated to Datawidth.
- FSM, two states:
  - IDLE: Valid_OUT=0. If fifo_count!=0, pop the head, then load hold and Out with the scaled value, set Valid_OUT=1, cot=0, hang=0, Last_OUT=(W*H==1), and go to EMIT.
  - EMIT: a beat transfers when Valid_OUT && Ready_IN. On transfer, cot increments. When cot==IMG_Width-1, cot goes to 0 and hang increments.
  - EMIT, Ready_IN=0: Out, Valid_OUT and Last_OUT hold stable.
  - EMIT, last transfer (cot==W-1, hang==H-1): if fifo_count!=0, pop the next value and start the next frame on the next cycle with no bubble (Valid_OUT stays 1, counters reset). Otherwise Valid_OUT<=0 and the FSM returns to IDLE.
  - Last_OUT is registered, high exactly while the current beat is at cot==W-1 && hang==H-1.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Latency: a sample accepted into an empty FIFO while IDLE at edge t gives Valid_OUT=1 after edge t+1.
- Throughput: one pixel per cycle while Ready_IN=1; one input accepted per W*H output beats in steady state.
- Pointers wrap modulo FIFO_Depth.
- Out is only meaningful while Valid_OUT=1, but it holds its last value otherwise.

Test Plan:
- Reset, then push In=98 with Scale=1 and Ready_IN held 1:
  - Valid_OUT rises one cycle after acceptance.
  - 49 consecutive beats of Out=2, Last_OUT only on beat 49.
  - Valid_OUT=0 afterwards and the FSM is IDLE.
- Push In=-100 with Scale=1:
  - ReLU=0: 49 beats of -2 (0xFFFE).
  - ReLU=1: 49 beats of 0.
- Push 147, then 49 back-to-back, with Ready_IN=1:
  - 49 beats of 3, then 49 beats of 1 with no idle cycle.
  - Last_OUT pulses on beats 49 and 98.
- Ready_IN toggles 1,0,0,1 repeatedly during a frame:
  - Out/Valid_OUT/Last_OUT stay stable while stalled.
  - Exactly 49 transfers occur; hang/cot reach 6/6 only at the final transfer.
- Ready_IN=0 and push 6 values continuously:
  - 1 value is popped into hold and 4 fill the FIFO.
  - Ready_OUT drops after the 5th acceptance and the 6th is not accepted until the first frame's final beat transfers.
  - Frame order is preserved.
- Assert CLR=0 asynchronously mid-frame (beat 20) with 2 entries queued:
  - Valid_OUT=0 immediately and Ready_OUT=1 after release.
  - No further beats until a new push.
